// File: rtl/slc3_ctrl_pkg.sv
// Shared types for the SLC-3 v2 control unit: state encoding, control word,
// opcodes and datapath mux encodings.
package slc3_ctrl_pkg;

  typedef enum logic [5:0] {
    S0      = 6'd0,  S1  = 6'd1,  S2  = 6'd2,  S3  = 6'd3,  S4  = 6'd4,
    S5      = 6'd5,  S6  = 6'd6,  S7  = 6'd7,  S9  = 6'd9,  S12 = 6'd12,
    S14     = 6'd14, S16 = 6'd16, S18 = 6'd18, S20 = 6'd20, S21 = 6'd21,
    S22     = 6'd22, S23 = 6'd23, S25 = 6'd25, S27 = 6'd27, S32 = 6'd32,
    S33     = 6'd33, S35 = 6'd35, HALTED = 6'd40, PAUSE_1 = 6'd41,
    PAUSE_2 = 6'd42, ILLEGAL = 6'd43
  } state_e;

  typedef struct packed {
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_ir;
    logic       ld_ben;
    logic       ld_reg;
    logic       ld_cc;
    logic       ld_pc;
    logic       ld_led;
    logic       gate_pc;
    logic       gate_mdr;
    logic       gate_alu;
    logic       gate_marmux;
    logic [1:0] pcmux;
    logic       dr_sel;    // 1: destination is R7
    logic       sr1mux;    // 0: IR[11:9], 1: IR[8:6]
    logic       sr2mux;    // follows IR[5] (immediate vs register)
    logic       addr1mux;  // 0: PC, 1: BaseR
    logic [1:0] addr2mux;
    logic [1:0] aluk;
    logic       mem_ena;
    logic       mem_wr;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_PSE = 4'b1101;
  localparam logic [3:0] OP_LEA = 4'b1110;

  localparam logic [1:0] PCMUX_PC1   = 2'b00;
  localparam logic [1:0] PCMUX_BUS   = 2'b01;
  localparam logic [1:0] PCMUX_ADDER = 2'b10;
  localparam logic [1:0] A2_ZERO     = 2'b00;
  localparam logic [1:0] A2_OFF6     = 2'b01;
  localparam logic [1:0] A2_OFF9     = 2'b10;
  localparam logic [1:0] A2_OFF11    = 2'b11;
  localparam logic [1:0] ALU_ADD     = 2'b00;
  localparam logic [1:0] ALU_AND     = 2'b01;
  localparam logic [1:0] ALU_NOT     = 2'b10;
  localparam logic [1:0] ALU_PASSA   = 2'b11;

  function automatic logic is_mem_state(input state_e s);
    return (s == S33) || (s == S25) || (s == S16);
  endfunction

endpackage

// File: rtl/slc3_ctrl_v2_mem_wait.sv
// Memory access stretcher: counts down MEM_WAIT-1 cycles after load, then
// waits for the device ready handshake.
module slc3_ctrl_v2_mem_wait #(
  parameter int unsigned MEM_WAIT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic rdy_i,
  output logic done_o
);
  localparam int unsigned CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(MEM_WAIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)              cnt_d = LOAD_VAL;
    else if (cnt_q != '0)    cnt_d = cnt_q - CW'(1);
    else                     cnt_d = cnt_q;
  end

  assign done_o = (cnt_q == '0) && rdy_i;
endmodule

// File: rtl/slc3_ctrl_v2.sv
// SLC-3 v2 control FSM: fetch/decode/execute sequencing with stretchable
// memory accesses, optional extended ISA, pause and illegal-opcode trap.
module slc3_ctrl_v2
  import slc3_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 3,
  parameter bit          EXT_ISA  = 1'b1,
  parameter bit          PAUSE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ir,
  input  logic        ben,
  input  logic        run_i,
  input  logic        continue_i,
  input  logic        mem_rdy,
  output ctrl_t       ctrl,
  output logic        halted_o,
  output logic        illegal_o,
  output logic [5:0]  state_o
);
  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   mem_load_s, mem_done_s;
  logic   unused_ir_s;

  assign unused_ir_s = ^{ir[10:6], ir[4:0]};

  slc3_ctrl_v2_mem_wait #(.MEM_WAIT(MEM_WAIT)) u_mem_wait (
    .clk    (clk),
    .reset  (reset),
    .load_i (mem_load_s),
    .rdy_i  (mem_rdy),
    .done_o (mem_done_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= HALTED;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HALTED:   state_d = run_i ? S18 : HALTED;
      S18:      state_d = S33;
      S33:      state_d = mem_done_s ? S35 : S33;
      S35:      state_d = S32;
      S32: begin
        case (ir[15:12])
          OP_ADD: state_d = S1;
          OP_AND: state_d = S5;
          OP_NOT: state_d = S9;
          OP_LDR: state_d = S6;
          OP_STR: state_d = S7;
          OP_JMP: state_d = S12;
          OP_BR:  state_d = S0;
          // JSRR (IR[11]=0) only exists with the extended ISA
          OP_JSR: state_d = (ir[11] || EXT_ISA) ? S4 : ILLEGAL;
          OP_LD:  state_d = EXT_ISA ? S2 : ILLEGAL;
          OP_ST:  state_d = EXT_ISA ? S3 : ILLEGAL;
          OP_LEA: state_d = EXT_ISA ? S14 : ILLEGAL;
          OP_PSE: state_d = PAUSE_EN ? PAUSE_1 : ILLEGAL;
          default: state_d = ILLEGAL;
        endcase
      end
      S6, S2:   state_d = S25;
      S25:      state_d = mem_done_s ? S27 : S25;
      S7, S3:   state_d = S23;
      S23:      state_d = S16;
      S16:      state_d = mem_done_s ? S18 : S16;
      S4:       state_d = ir[11] ? S21 : S20;
      S0:       state_d = ben ? S22 : S18;
      PAUSE_1:  state_d = continue_i ? PAUSE_2 : PAUSE_1;
      PAUSE_2:  state_d = continue_i ? PAUSE_2 : S18;
      ILLEGAL:  state_d = HALTED;
      S1, S5, S9, S14, S27, S21, S20, S12, S22: state_d = S18;
      default:  state_d = HALTED;
    endcase
  end

  // Counter reloads only on entry into a memory state, never while holding.
  assign mem_load_s = is_mem_state(state_d) && (state_d != state_q);

  always_comb begin
    illegal_d = illegal_q;
    if (state_d == ILLEGAL)               illegal_d = 1'b1;
    else if (state_q == HALTED && run_i)  illegal_d = 1'b0;
    else                                  illegal_d = illegal_q;
  end

  always_comb begin
    ctrl = CTRL_IDLE;
    case (state_q)
      S18: begin
        ctrl.gate_pc = 1'b1; ctrl.ld_mar = 1'b1; ctrl.ld_pc = 1'b1; ctrl.pcmux = PCMUX_PC1;
      end
      S33, S25: begin ctrl.mem_ena = 1'b1; ctrl.ld_mdr = 1'b1; end
      S35:      begin ctrl.gate_mdr = 1'b1; ctrl.ld_ir = 1'b1; end
      S32:      ctrl.ld_ben = 1'b1;
      S1, S5, S9: begin
        ctrl.ld_reg = 1'b1; ctrl.ld_cc = 1'b1; ctrl.gate_alu = 1'b1;
        ctrl.sr1mux = 1'b1; ctrl.sr2mux = ir[5];
        ctrl.aluk = (state_q == S1) ? ALU_ADD : ((state_q == S5) ? ALU_AND : ALU_NOT);
      end
      S6, S7: begin
        ctrl.ld_mar = 1'b1; ctrl.gate_marmux = 1'b1;
        ctrl.addr1mux = 1'b1; ctrl.sr1mux = 1'b1; ctrl.addr2mux = A2_OFF6;
      end
      S2, S3:   begin ctrl.ld_mar = 1'b1; ctrl.gate_marmux = 1'b1; ctrl.addr2mux = A2_OFF9; end
      S27:      begin ctrl.gate_mdr = 1'b1; ctrl.ld_reg = 1'b1; ctrl.ld_cc = 1'b1; end
      S23:      begin ctrl.ld_mdr = 1'b1; ctrl.gate_alu = 1'b1; ctrl.aluk = ALU_PASSA; end
      S16:      begin ctrl.mem_ena = 1'b1; ctrl.mem_wr = 1'b1; end
      S14: begin
        ctrl.ld_reg = 1'b1; ctrl.ld_cc = 1'b1; ctrl.gate_marmux = 1'b1; ctrl.addr2mux = A2_OFF9;
      end
      S4:       begin ctrl.ld_reg = 1'b1; ctrl.dr_sel = 1'b1; ctrl.gate_pc = 1'b1; end
      S21:      begin ctrl.ld_pc = 1'b1; ctrl.pcmux = PCMUX_ADDER; ctrl.addr2mux = A2_OFF11; end
      // BaseR + 0 through the address adder
      S20, S12: begin
        ctrl.ld_pc = 1'b1; ctrl.pcmux = PCMUX_ADDER; ctrl.addr1mux = 1'b1;
        ctrl.sr1mux = 1'b1; ctrl.addr2mux = A2_ZERO;
      end
      S22:      begin ctrl.ld_pc = 1'b1; ctrl.pcmux = PCMUX_ADDER; ctrl.addr2mux = A2_OFF9; end
      PAUSE_1, PAUSE_2: ctrl.ld_led = 1'b1;
      default:  ctrl = CTRL_IDLE;
    endcase
  end

  assign halted_o  = (state_q == HALTED);
  assign illegal_o = illegal_q;
  assign state_o   = state_q;
endmodule

// File: tb/tb_slc3_ctrl_v2.sv
// Randomized bench for slc3_ctrl_v2: an instruction-level path model predicts
// the state walk and key control lines for two parameter configurations.
module tb_slc3_ctrl_v2;
  import slc3_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] ir_s [2];
  logic        ben_s [2], run_s [2], cont_s [2], rdy_s [2];
  ctrl_t       ctrl_v [2];
  logic        halted_v [2], illegal_v [2];
  logic [5:0]  state_v [2];

  int          n_checks = 0;
  int          n_errors = 0;
  bit          exp_ill [2];
  int          memwr_cnt, s25_cycles, cyc;
  int          wait_of [2] = '{3, 5};
  bit          ext_of  [2] = '{1'b1, 1'b0};
  bit          pse_of  [2] = '{1'b1, 1'b0};
  state_e      path_q [$];

  always #5 clk = ~clk;

  slc3_ctrl_v2 #(.MEM_WAIT(3), .EXT_ISA(1'b1), .PAUSE_EN(1'b1)) dut_a (
    .clk(clk), .reset(reset), .ir(ir_s[0]), .ben(ben_s[0]), .run_i(run_s[0]),
    .continue_i(cont_s[0]), .mem_rdy(rdy_s[0]), .ctrl(ctrl_v[0]),
    .halted_o(halted_v[0]), .illegal_o(illegal_v[0]), .state_o(state_v[0]));

  slc3_ctrl_v2 #(.MEM_WAIT(5), .EXT_ISA(1'b0), .PAUSE_EN(1'b0)) dut_b (
    .clk(clk), .reset(reset), .ir(ir_s[1]), .ben(ben_s[1]), .run_i(run_s[1]),
    .continue_i(cont_s[1]), .mem_rdy(rdy_s[1]), .ctrl(ctrl_v[1]),
    .halted_o(halted_v[1]), .illegal_o(illegal_v[1]), .state_o(state_v[1]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected state sequence of one instruction, from S18 up to the next S18 (or HALTED).
  function automatic void build_path(input int u, input logic [15:0] irv, input logic benv);
    bit bad = 1'b0;
    path_q = '{S18, S33, S35, S32};
    case (irv[15:12])
      4'b0001: path_q.push_back(S1);
      4'b0101: path_q.push_back(S5);
      4'b1001: path_q.push_back(S9);
      4'b0110: begin path_q.push_back(S6); path_q.push_back(S25); path_q.push_back(S27); end
      4'b0111: begin path_q.push_back(S7); path_q.push_back(S23); path_q.push_back(S16); end
      4'b0010: if (ext_of[u]) begin path_q.push_back(S2); path_q.push_back(S25); path_q.push_back(S27); end
               else bad = 1'b1;
      4'b0011: if (ext_of[u]) begin path_q.push_back(S3); path_q.push_back(S23); path_q.push_back(S16); end
               else bad = 1'b1;
      4'b1110: if (ext_of[u]) path_q.push_back(S14); else bad = 1'b1;
      4'b0100: if (irv[11]) begin path_q.push_back(S4); path_q.push_back(S21); end
               else if (ext_of[u]) begin path_q.push_back(S4); path_q.push_back(S20); end
               else bad = 1'b1;
      4'b1100: path_q.push_back(S12);
      4'b0000: begin path_q.push_back(S0); if (benv) path_q.push_back(S22); end
      4'b1101: if (pse_of[u]) begin path_q.push_back(PAUSE_1); path_q.push_back(PAUSE_2); end
               else bad = 1'b1;
      default: bad = 1'b1;
    endcase
    if (bad) begin path_q.push_back(ILLEGAL); path_q.push_back(HALTED); end
    else path_q.push_back(S18);
  endfunction

  task automatic check_outputs(input int u, input state_e es);
    check("state",   32'(state_v[u]), 32'(es));
    check("halted",  32'(halted_v[u]), 32'(es == HALTED));
    check("illegal", 32'(illegal_v[u]), 32'(exp_ill[u]));
    check("mem_ena", 32'(ctrl_v[u].mem_ena), 32'(es inside {S33, S25, S16}));
    check("mem_wr",  32'(ctrl_v[u].mem_wr), 32'(es == S16));
    check("ld_pc",   32'(ctrl_v[u].ld_pc), 32'(es inside {S18, S21, S20, S12, S22}));
    check("ld_reg",  32'(ctrl_v[u].ld_reg), 32'(es inside {S1, S5, S9, S27, S14, S4}));
    check("ld_ben",  32'(ctrl_v[u].ld_ben), 32'(es == S32));
    check("ld_led",  32'(ctrl_v[u].ld_led), 32'(es inside {PAUSE_1, PAUSE_2}));
    case (es)
      S6, S7:       begin check("addr1mux", 32'(ctrl_v[u].addr1mux), 32'd1);
                          check("addr2mux", 32'(ctrl_v[u].addr2mux), 32'd1); end
      S2, S3, S14:  begin check("addr1mux", 32'(ctrl_v[u].addr1mux), 32'd0);
                          check("addr2mux", 32'(ctrl_v[u].addr2mux), 32'd2); end
      S22:          begin check("pcmux", 32'(ctrl_v[u].pcmux), 32'd2);
                          check("addr2mux", 32'(ctrl_v[u].addr2mux), 32'd2); end
      S21:          begin check("pcmux", 32'(ctrl_v[u].pcmux), 32'd2);
                          check("addr2mux", 32'(ctrl_v[u].addr2mux), 32'd3); end
      S18:          check("pcmux", 32'(ctrl_v[u].pcmux), 32'd0);
      S1:           check("aluk", 32'(ctrl_v[u].aluk), 32'd0);
      S5:           check("aluk", 32'(ctrl_v[u].aluk), 32'd1);
      S9:           check("aluk", 32'(ctrl_v[u].aluk), 32'd2);
      S23:          check("aluk", 32'(ctrl_v[u].aluk), 32'd3);
      S4:           check("dr_sel", 32'(ctrl_v[u].dr_sel), 32'd1);
      HALTED:       check("idle", 32'(ctrl_v[u]), 32'(CTRL_IDLE));
      default: ;
    endcase
  endtask

  // rdy_mode: 0 random, 1 always ready, 2 ready held low 4 extra cycles in S25.
  task automatic walk(input int u, input logic [15:0] irv, input logic benv,
                      input int rdy_mode, input bit stop16, output int cycles);
    int idx = 0, dwell = 0;
    bit adv;
    state_e es;
    build_path(u, irv, benv);
    ir_s[u] = irv; ben_s[u] = benv;
    cycles = 0; memwr_cnt = 0; s25_cycles = 0;
    while (idx < path_q.size() - 1 && cycles < 400) begin
      es = path_q[idx];
      if (stop16 && es == S16 && dwell == 1) break;
      case (rdy_mode)
        1:       rdy_s[u] = 1'b1;
        2:       rdy_s[u] = (es == S25) ? (dwell >= wait_of[u] + 3) : 1'b1;
        default: rdy_s[u] = ($urandom_range(0, 3) != 0);
      endcase
      cont_s[u] = 1'($urandom_range(0, 1));
      run_s[u]  = 1'($urandom_range(0, 1));
      @(posedge clk);
      cycles++; dwell++;
      case (es)
        S33, S25, S16: adv = (dwell >= wait_of[u]) && rdy_s[u];
        PAUSE_1:       adv = cont_s[u];
        PAUSE_2:       adv = !cont_s[u];
        default:       adv = 1'b1;
      endcase
      if (adv) begin
        if (es == S25) s25_cycles = dwell;
        idx++; dwell = 0;
        if (path_q[idx] == ILLEGAL) exp_ill[u] = 1'b1;
      end
      #1;
      check_outputs(u, path_q[idx]);
      if (path_q[idx] == S16 && ctrl_v[u].mem_wr) memwr_cnt++;
    end
    if (!stop16) check("walk_done", 32'(idx), 32'(path_q.size() - 1));
    run_s[u] = 1'b0;
  endtask

  // HALTED holds without run_i, then run_i restarts at S18 and clears illegal_o.
  task automatic start(input int u);
    for (int k = 0; k < 3; k++) begin
      run_s[u] = (k == 2);
      @(posedge clk);
      if (k == 2) exp_ill[u] = 1'b0;
      #1;
      check_outputs(u, (k == 2) ? S18 : HALTED);
    end
    run_s[u] = 1'b0;
  endtask

  initial begin
    logic [15:0] r_ir;
    for (int u = 0; u < 2; u++) begin
      ir_s[u] = 16'h0000; ben_s[u] = 1'b0; run_s[u] = 1'b0;
      cont_s[u] = 1'b0; rdy_s[u] = 1'b0; exp_ill[u] = 1'b0;
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs(0, HALTED);
    check_outputs(1, HALTED);
    reset = 1'b0;

    // Narrow configuration: MEM_WAIT=5, no extended ISA, no pause.
    start(1);
    walk(1, 16'h2000, 1'b0, 1, 1'b0, cyc);
    check("ld_illegal_sticky", 32'(illegal_v[1]), 32'd1);
    start(1);
    walk(1, 16'h6000, 1'b0, 2, 1'b0, cyc);
    check("s25_stretch", 32'(s25_cycles), 32'd9);
    for (int n = 0; n < 30; n++) begin
      r_ir = 16'($urandom);
      walk(1, r_ir, 1'($urandom_range(0, 1)), 0, 1'b0, cyc);
      if (path_q[path_q.size() - 1] == HALTED) start(1);
    end
    walk(1, 16'hD000, 1'b0, 0, 1'b0, cyc);

    // Full configuration: MEM_WAIT=3, extended ISA, pause.
    start(0);
    walk(0, 16'h1265, 1'b0, 1, 1'b0, cyc);
    check("add_cycles", 32'(cyc), 32'd7);
    walk(0, 16'h74FF, 1'b0, 1, 1'b0, cyc);
    check("str_memwr_cycles", 32'(memwr_cnt), 32'd3);
    walk(0, 16'h0800, 1'b0, 1, 1'b0, cyc);
    check("br_nt_cycles", 32'(cyc), 32'd7);
    walk(0, 16'h0800, 1'b1, 1, 1'b0, cyc);
    check("br_t_cycles", 32'(cyc), 32'd8);
    for (int n = 0; n < 40; n++) begin
      r_ir = 16'($urandom);
      walk(0, r_ir, 1'($urandom_range(0, 1)), 0, 1'b0, cyc);
      if (path_q[path_q.size() - 1] == HALTED) start(0);
    end

    // Reset during the second S16 cycle of a store; unit 1 sits halted with illegal_o set.
    walk(0, 16'h74FF, 1'b0, 1, 1'b1, cyc);
    check("pre_reset_s16", 32'(state_v[0]), 32'(S16));
    check("pre_reset_ill", 32'(illegal_v[1]), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    exp_ill[0] = 1'b0; exp_ill[1] = 1'b0;
    #1;
    check_outputs(0, HALTED);
    check_outputs(1, HALTED);
    reset = 1'b0;
    start(0);
    walk(0, 16'h1265, 1'b0, 1, 1'b0, cyc);
    check("post_reset_add", 32'(cyc), 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
